sar_dll_ctrl: RTL

Parametrised successive-approximation delay-line controller for the DLL loop, and the next generation of the fixed 10-bit SAR. It performs a WIDTH-step binary search on the delay code from the phase-detector lead/lag bit (comp). It then optionally enters a ±1 tracking mode with lock detection. Per-step settle wait and a start/done handshake let the digital loop sequencer launch re-calibration.

---
 rtl/sar_dll_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sar_dll_ctrl.sv
// sar_dll_ctrl: successive-approximation delay-code search for the DLL loop,
// followed by optional +/-1 tracking with reversal-based lock detection.
// All state advances on the falling edge of clk4.
module sar_dll_ctrl #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned SETTLE   = 0,
  parameter int unsigned TRACK_EN = 1,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                     clk4,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     comp,
  output logic [WIDTH-1:0]         code,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     locked
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned CW = 4;

  localparam logic [WIDTH-1:0] CODE_MID  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] CODE_MAX  = '1;
  localparam logic [WIDTH-1:0] CODE_MIN  = '0;
  localparam logic [IW-1:0]    IDX_TOP   = IW'(WIDTH - 1);
  localparam logic [CW-1:0]    SETTLE_LD = CW'(SETTLE);
  localparam logic [CW-1:0]    LOCK_LIM  = CW'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAR   = 2'd1,
    ST_TRACK = 2'd2
  } state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] code_q,   code_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             locked_q, locked_d;
  logic [CW-1:0]    settle_q, settle_d;
  logic [CW-1:0]    rev_q,    rev_d;
  logic [CW-1:0]    run_q,    run_d;
  logic             dir_q,    dir_d;
  logic             dvld_q,   dvld_d;

  // Next-state and next-output logic for the search / tracking loop.
  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    locked_d = locked_q;
    settle_d = settle_q;
    rev_d    = rev_q;
    run_d    = run_q;
    dir_d    = dir_q;
    dvld_d   = dvld_q;

    if (start) begin
      // Restart wins over any decision pending in this cycle.
      state_d  = ST_SAR;
      code_d   = CODE_MID;
      idx_d    = IDX_TOP;
      busy_d   = 1'b1;
      locked_d = 1'b0;
      settle_d = SETTLE_LD;
      rev_d    = '0;
      run_d    = '0;
      dir_d    = 1'b0;
      dvld_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_SAR: begin
          if (settle_q != '0) begin
            settle_d = settle_q - CW'(1);
          end else begin
            code_d[idx_q] = comp;
            if (idx_q != '0) begin
              code_d[idx_q - IW'(1)] = 1'b1;
              idx_d    = idx_q - IW'(1);
              settle_d = SETTLE_LD;
            end else begin
              done_d   = 1'b1;
              busy_d   = 1'b0;
              settle_d = SETTLE_LD;
              state_d  = (TRACK_EN != 0) ? ST_TRACK : ST_IDLE;
            end
          end
        end

        ST_TRACK: begin
          if (settle_q != '0) begin
            settle_d = settle_q - CW'(1);
          end else begin
            // Saturating +/-1 step; a suppressed step still has a direction.
            if (comp) begin
              if (code_q != CODE_MAX) code_d = code_q + WIDTH'(1);
            end else begin
              if (code_q != CODE_MIN) code_d = code_q - WIDTH'(1);
            end
            settle_d = SETTLE_LD;
            dir_d    = comp;
            dvld_d   = 1'b1;
            if (dvld_q) begin
              if (comp != dir_q) begin
                rev_d = (rev_q == LOCK_LIM) ? rev_q : rev_q + CW'(1);
                run_d = '0;
              end else begin
                run_d = (run_q == LOCK_LIM) ? run_q : run_q + CW'(1);
                rev_d = '0;
              end
              if (rev_d == LOCK_LIM) begin
                locked_d = 1'b1;
              end else if (run_d == LOCK_LIM) begin
                locked_d = 1'b0;
              end
            end
          end
        end

        default: begin
          // IDLE: hold code, bit index and lock; comp is ignored.
        end
      endcase
    end
  end

  // State and output registers, falling-edge clocked with async reset.
  always_ff @(negedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      code_q   <= CODE_MID;
      idx_q    <= IDX_TOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      settle_q <= '0;
      rev_q    <= '0;
      run_q    <= '0;
      dir_q    <= 1'b0;
      dvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      locked_q <= locked_d;
      settle_q <= settle_d;
      rev_q    <= rev_d;
      run_q    <= run_d;
      dir_q    <= dir_d;
      dvld_q   <= dvld_d;
    end
  end

  assign code    = code_q;
  assign bit_idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign locked  = locked_q;

endmodule
